// File: rtl/kf_in_service_ctrl_if.sv
// rtl/kf_in_service_ctrl_if.sv - acknowledge/command/status bundle for the in-service controller
interface kf_in_service_ctrl_if #(
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W    = $clog2(NUM_LEVELS)
);
  logic                  ack_strobe;
  logic [NUM_LEVELS-1:0] ack_vector;
  logic                  ack_done;
  logic                  aeoi_mode;
  logic                  aeoi_rotate;
  logic                  cmd_valid;
  logic [2:0]            cmd_type;
  logic [LEVEL_W-1:0]    cmd_level;
  logic [NUM_LEVELS-1:0] special_mask;
  logic [NUM_LEVELS-1:0] in_service_register;
  logic [NUM_LEVELS-1:0] highest_level_in_service;
  logic [LEVEL_W-1:0]    lowest_priority;
  logic                  aeoi_pending;

  modport master (
    output ack_strobe, ack_vector, ack_done, aeoi_mode, aeoi_rotate,
           cmd_valid, cmd_type, cmd_level, special_mask,
    input  in_service_register, highest_level_in_service, lowest_priority, aeoi_pending
  );

  modport slave (
    input  ack_strobe, ack_vector, ack_done, aeoi_mode, aeoi_rotate,
           cmd_valid, cmd_type, cmd_level, special_mask,
    output in_service_register, highest_level_in_service, lowest_priority, aeoi_pending
  );
endinterface

// File: rtl/kf_in_service_ctrl.sv
// rtl/kf_in_service_ctrl.sv - interrupt in-service register with EOI, rotation and automatic EOI
module kf_in_service_ctrl #(
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  logic                 clock,
  input  logic                 reset,
  kf_in_service_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, ACK_WAIT} state_t;

  localparam logic [NUM_LEVELS-1:0] ONE_VEC   = {{(NUM_LEVELS-1){1'b0}}, 1'b1};
  localparam logic [LEVEL_W:0]      ONE_IDX   = {{LEVEL_W{1'b0}}, 1'b1};
  localparam logic [LEVEL_W:0]      LEVELS_IX = (LEVEL_W+1)'(NUM_LEVELS);
  localparam logic [LEVEL_W-1:0]    LOWEST_RST = LEVEL_W'(NUM_LEVELS-1);

  state_t                state_q, state_d;
  logic [LEVEL_W-1:0]    ack_level_q, ack_level_d;
  logic [NUM_LEVELS-1:0] isr_q, isr_d;
  logic [NUM_LEVELS-1:0] highest_q, highest_d;
  logic [LEVEL_W-1:0]    lowest_q, lowest_d;

  // Rotate so the level after lp sits at bit 0, isolate the lowest set bit, rotate back.
  function automatic logic [NUM_LEVELS-1:0] resolve(input logic [NUM_LEVELS-1:0] v,
                                                    input logic [LEVEL_W-1:0]    lp);
    logic [LEVEL_W:0]        s;
    logic [2*NUM_LEVELS-1:0] dbl;
    logic [NUM_LEVELS-1:0]   r;
    logic [NUM_LEVELS-1:0]   p;
    s = {1'b0, lp} + ONE_IDX;
    if (s >= LEVELS_IX) s = '0;
    dbl = {v, v} >> s;
    r   = dbl[NUM_LEVELS-1:0];
    p   = r & (~r + ONE_VEC);
    dbl = {p, p} << s;
    return dbl[2*NUM_LEVELS-1:NUM_LEVELS];
  endfunction

  function automatic logic [LEVEL_W-1:0] onehot_to_idx(input logic [NUM_LEVELS-1:0] v);
    logic [LEVEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (v[i]) idx = LEVEL_W'(i);
    end
    return idx;
  endfunction

  // State register with asynchronous reset; level 0 starts as highest priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ack_level_q <= '0;
      isr_q       <= '0;
      highest_q   <= '0;
      lowest_q    <= LOWEST_RST;
    end else begin
      state_q     <= state_d;
      ack_level_q <= ack_level_d;
      isr_q       <= isr_d;
      highest_q   <= highest_d;
      lowest_q    <= lowest_d;
    end
  end

  logic [NUM_LEVELS-1:0] masked_isr;
  logic [NUM_LEVELS-1:0] ns_pick;
  logic [NUM_LEVELS-1:0] clear_vec;
  logic [NUM_LEVELS-1:0] cmd_onehot;
  logic                  ack_valid;
  logic                  level_ok;

  // Next-state: FSM for automatic EOI, then commands (whose rotation overrides AEOI rotation).
  always_comb begin
    state_d     = state_q;
    ack_level_d = ack_level_q;
    lowest_d    = lowest_q;
    clear_vec   = '0;
    masked_isr  = isr_q & ~bus.special_mask;
    ns_pick     = resolve(masked_isr, lowest_q);
    ack_valid   = bus.ack_strobe && (bus.ack_vector != '0);
    level_ok    = ({1'b0, bus.cmd_level} < LEVELS_IX);
    cmd_onehot  = ONE_VEC << bus.cmd_level;

    case (state_q)
      IDLE: begin
        if (ack_valid && bus.aeoi_mode) begin
          state_d     = ACK_WAIT;
          ack_level_d = onehot_to_idx(bus.ack_vector);
        end
      end
      ACK_WAIT: begin
        if (bus.ack_done) begin
          clear_vec = clear_vec | (ONE_VEC << ack_level_q);
          if (bus.aeoi_rotate) lowest_d = ack_level_q;
          state_d = (ack_valid && bus.aeoi_mode) ? ACK_WAIT : IDLE;
        end
        if (ack_valid) ack_level_d = onehot_to_idx(bus.ack_vector);
      end
      default: state_d = IDLE;
    endcase

    if (bus.cmd_valid) begin
      case (bus.cmd_type)
        3'd0: clear_vec = clear_vec | ns_pick;
        3'd2: begin
          if (masked_isr != '0) begin
            clear_vec = clear_vec | ns_pick;
            lowest_d  = onehot_to_idx(ns_pick);
          end
        end
        3'd1: if (level_ok) clear_vec = clear_vec | cmd_onehot;
        3'd3: begin
          if (level_ok) begin
            clear_vec = clear_vec | cmd_onehot;
            lowest_d  = bus.cmd_level;
          end
        end
        3'd4: if (level_ok) lowest_d = bus.cmd_level;
        default: ;
      endcase
    end

    isr_d     = (isr_q & ~clear_vec) | (bus.ack_strobe ? bus.ack_vector : '0);
    highest_d = resolve(isr_d & ~bus.special_mask, lowest_d);
  end

  assign bus.in_service_register      = isr_q;
  assign bus.highest_level_in_service = highest_q;
  assign bus.lowest_priority          = lowest_q;
  assign bus.aeoi_pending             = (state_q == ACK_WAIT);

endmodule
